// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI responder that exposes a 2^ADDR_W x 8 register file to an external initiator.
// Latency: pin edges act 3 sys_clk after the edge; wr_en and reg_out update 1 sys_clk after the 8th sample.
// Backpressure: none; the initiator sets the pace, and each sclk phase must last at least 4 sys_clk.
//
// Ports:
//   sys_clk, sys_rst_n  system clock, asynchronous active-low reset
//   cs, sclk, mosi      SPI pins, asynchronous to sys_clk, oversampled through 2-flop synchronisers
//   miso                responder data, MSB first, forced to 0 while synchronised cs is high
//   reg_out             flat register file, reg n at [8n+7:8n]
//   wr_en/wr_addr/wr_data  one-cycle write notification per committed data byte
//   frame_done          one-cycle pulse when cs rises after at least one complete byte
module spi_reg_slave #(
    parameter logic       CPOL        = 1'b1,
    parameter logic       CPHA        = 1'b1,
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] STATUS_BYTE = 8'h5A
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       cs,
    input  logic                       sclk,
    input  logic                       mosi,
    output logic                       miso,
    output logic [8*(2**ADDR_W)-1:0]   reg_out,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 wr_data,
    output logic                       frame_done
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        CMD,
        DATA
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_cs_sync;
    logic [1:0]              r_sclk_sync;
    logic [1:0]              r_mosi_sync;
    logic                    r_sclk_d;
    logic [DEPTH-1:0][7:0]   r_regs;
    logic [7:0]              r_rx;
    logic [7:0]              r_tx;
    logic [2:0]              r_bitcnt;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_is_read;
    logic                    r_got_byte;
    logic                    r_miso;
    logic                    r_wr_en;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [7:0]              r_wr_data;
    logic                    r_frame_done;

    logic                    w_cs_s;
    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic                    w_lead;
    logic                    w_trail;
    logic                    w_sample;
    logic                    w_shift;
    logic                    w_byte_end;
    logic [7:0]              w_rx_byte;
    logic [ADDR_W-1:0]       w_cmd_addr;
    logic [ADDR_W-1:0]       w_addr_inc;

    assign w_cs_s      = r_cs_sync[1];
    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
    // Leading edge moves sclk away from its idle level.
    assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = CPHA ? w_trail : w_lead;
    assign w_shift     = CPHA ? w_lead : w_trail;
    assign w_byte_end  = w_sample && (r_bitcnt == 3'd7);
    // mosi goes through the same synchroniser depth as sclk, so it is aligned with the detected edge.
    assign w_rx_byte   = {r_rx[6:0], r_mosi_sync[1]};
    assign w_cmd_addr  = w_rx_byte[ADDR_W-1:0];
    assign w_addr_inc  = r_addr + ADDR_W'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // cs syncs clear low so a frame already running at release is held off in WAIT_IDLE.
            r_cs_sync   <= 2'b00;
            r_sclk_sync <= {2{CPOL}};
            r_sclk_d    <= CPOL;
            r_mosi_sync <= 2'b00;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], cs};
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_sclk_d    <= r_sclk_sync[1];
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= WAIT_IDLE;
            r_regs       <= '0;
            r_rx         <= 8'h00;
            r_tx         <= 8'h00;
            r_bitcnt     <= 3'd0;
            r_addr       <= '0;
            r_is_read    <= 1'b0;
            r_got_byte   <= 1'b0;
            r_miso       <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                WAIT_IDLE: begin
                    if (w_cs_s) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    r_miso <= 1'b0;
                    if (!w_cs_s) begin
                        r_state    <= CMD;
                        r_bitcnt   <= 3'd0;
                        r_got_byte <= 1'b0;
                        // With CPHA=0 there is no shift edge before the first sample, so the
                        // MSB goes out right at cs fall and the shifter holds the remaining bits.
                        if (!CPHA) begin
                            r_miso <= STATUS_BYTE[7];
                            r_tx   <= {STATUS_BYTE[6:0], 1'b0};
                        end else begin
                            r_tx   <= STATUS_BYTE;
                        end
                    end
                end
                CMD, DATA: begin
                    if (w_sample) begin
                        r_rx     <= w_rx_byte;
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    if (w_shift) begin
                        r_miso <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end
                    if (w_byte_end) begin
                        r_got_byte <= 1'b1;
                        if (r_state == CMD) begin
                            r_state   <= DATA;
                            r_is_read <= w_rx_byte[7];
                            r_addr    <= w_cmd_addr;
                            r_tx      <= w_rx_byte[7] ? r_regs[w_cmd_addr] : 8'h00;
                        end else if (r_is_read) begin
                            r_addr <= w_addr_inc;
                            r_tx   <= r_regs[w_addr_inc];
                        end else begin
                            // Register and wr_en land on the same edge so reg_out matches the pulse.
                            r_regs[r_addr] <= w_rx_byte;
                            r_wr_en        <= 1'b1;
                            r_wr_addr      <= r_addr;
                            r_wr_data      <= w_rx_byte;
                            r_addr         <= w_addr_inc;
                            r_tx           <= 8'h00;
                        end
                    end
                    // cs rise wins over state, but a byte finishing on the same cycle is still counted.
                    if (w_cs_s) begin
                        r_state <= IDLE;
                        r_miso  <= 1'b0;
                        if (r_got_byte || w_byte_end) begin
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= WAIT_IDLE;
            endcase
        end
    end

    assign miso       = r_miso & ~w_cs_s;
    assign reg_out    = r_regs;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: drives four responders, one per CPOL/CPHA mode, from a behavioural SPI initiator.
// Latency: each sclk phase lasts H sys_clk; results are scored after each scenario's frames.
// Backpressure: none; the initiator model runs at a fixed bit rate.
module tb_spi_reg_slave;
    localparam int H = 6;

    typedef struct {
        int         m;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] r;
    } obs_t;

    typedef struct {
        int         m;
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         cs_r     [4];
    logic         sclk_r   [4];
    logic         mosi_r   [4];
    logic         miso_w   [4];
    logic [127:0] reg_out_w [4];
    logic         wr_en_w  [4];
    logic [3:0]   wr_addr_w [4];
    logic [7:0]   wr_data_w [4];
    logic         fd_w     [4];

    int           vectors = 0;
    int           miscompares = 0;
    int           fd_cnt [4] = '{0, 0, 0, 0};
    obs_t         obs_q [$];
    int           obs_rd = 0;
    logic [7:0]   got_q [$];
    logic [7:0]   exp_miso [$];
    wr_t          exp_wr [$];
    logic [7:0]   tx_q [$];
    logic [7:0]   mdl [4][16];

    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam logic P_CPOL = logic'(g / 2);
        localparam logic P_CPHA = logic'(g % 2);
        spi_reg_slave #(
            .CPOL(P_CPOL),
            .CPHA(P_CPHA),
            .ADDR_W(4),
            .STATUS_BYTE(8'h5A)
        ) u_dut (
            .sys_clk(sys_clk),
            .sys_rst_n(sys_rst_n),
            .cs(cs_r[g]),
            .sclk(sclk_r[g]),
            .mosi(mosi_r[g]),
            .miso(miso_w[g]),
            .reg_out(reg_out_w[g]),
            .wr_en(wr_en_w[g]),
            .wr_addr(wr_addr_w[g]),
            .wr_data(wr_data_w[g]),
            .frame_done(fd_w[g])
        );
    end

    // Records every write pulse (with the reg_out byte seen in that cycle) and every frame_done pulse.
    always @(negedge sys_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en_w[k] === 1'b1) begin
                obs_t o;
                o.m = k;
                o.a = wr_addr_w[k];
                o.d = wr_data_w[k];
                o.r = reg_out_w[k][8*wr_addr_w[k] +: 8];
                obs_q.push_back(o);
            end
            if (fd_w[k] === 1'b1) fd_cnt[k]++;
        end
    end

    task automatic half();
        repeat (H) @(negedge sys_clk);
    endtask

    task automatic xfer(input int m, input logic [7:0] b, input int nbits);
        logic       cpol;
        logic [7:0] rx;
        cpol = m[1];
        rx   = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (m[0] == 1'b0) begin
                mosi_r[m] = b[i];
                half();
                sclk_r[m] = ~cpol;
                rx[i] = miso_w[m];
                half();
                sclk_r[m] = cpol;
            end else begin
                sclk_r[m] = ~cpol;
                mosi_r[m] = b[i];
                half();
                sclk_r[m] = cpol;
                rx[i] = miso_w[m];
                half();
            end
        end
        if (nbits == 8) got_q.push_back(rx);
    endtask

    task automatic send_frame(input int m, input int last_bits);
        cs_r[m] = 1'b0;
        half();
        for (int i = 0; i < tx_q.size(); i++) begin
            xfer(m, tx_q[i], (i == tx_q.size() - 1) ? last_bits : 8);
        end
        half();
        cs_r[m] = 1'b1;
        half();
        half();
    endtask

    task automatic push_wr(input int m, input logic [3:0] a, input logic [7:0] d);
        wr_t w;
        w.m = m;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
        mdl[m][a] = d;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (reg_out_w[k] !== 128'h0) begin
                miscompares++;
                $display("FAIL reset_reg_out m%0d: got %h expected 0", k, reg_out_w[k]);
            end
            vectors++;
            if (miso_w[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_miso m%0d: got %b expected 0", k, miso_w[k]);
            end
            vectors++;
            if (wr_en_w[k] !== 1'b0 || wr_addr_w[k] !== 4'h0 || wr_data_w[k] !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_wr m%0d: got en=%b a=%h d=%h expected 0/0/0", k, wr_en_w[k], wr_addr_w[k], wr_data_w[k]);
            end
            vectors++;
            if (fd_w[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_frame_done m%0d: got %b expected 0", k, fd_w[k]);
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_no_writes: got %0d writes expected 0", obs_q.size());
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_write_read(input int m);
        int           fd0;
        int           fd_exp;
        logic [7:0]   e;
        logic [7:0]   g;
        wr_t          ew;
        obs_t         ow;
        logic [127:0] exp_flat;
        fd0 = fd_cnt[m];
        fd_exp = 0;
        tx_q = '{8'h03, 8'hC4};
        exp_miso.push_back(8'h5A);
        exp_miso.push_back(8'h00);
        push_wr(m, 4'h3, 8'hC4);
        send_frame(m, 8);
        fd_exp++;
        tx_q = '{8'h83, 8'h00};
        exp_miso.push_back(8'h5A);
        exp_miso.push_back(mdl[m][3]);
        send_frame(m, 8);
        fd_exp++;
        while (exp_miso.size() > 0) begin
            e = exp_miso.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_rd_miso m%0d: got no byte expected %h", m, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL wr_rd_miso m%0d: got %h expected %h", m, g, e);
                end
            end
        end
        got_q.delete();
        while (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            vectors++;
            if (obs_rd >= obs_q.size()) begin
                miscompares++;
                $display("FAIL wr_rd_write m%0d: got none expected a=%h d=%h", m, ew.a, ew.d);
            end else begin
                ow = obs_q[obs_rd];
                obs_rd++;
                if (ow.m != ew.m || ow.a !== ew.a || ow.d !== ew.d || ow.r !== ew.d) begin
                    miscompares++;
                    $display("FAIL wr_rd_write m%0d: got m%0d a=%h d=%h reg=%h expected m%0d a=%h d=%h", m, ow.m, ow.a, ow.d, ow.r, ew.m, ew.a, ew.d);
                end
            end
        end
        vectors++;
        if (obs_q.size() != obs_rd) begin
            miscompares++;
            $display("FAIL wr_rd_extra_writes m%0d: got %0d extra expected 0", m, obs_q.size() - obs_rd);
        end
        obs_rd = obs_q.size();
        vectors++;
        if (fd_cnt[m] - fd0 != fd_exp) begin
            miscompares++;
            $display("FAIL wr_rd_frame_done m%0d: got %0d expected %0d", m, fd_cnt[m] - fd0, fd_exp);
        end
        for (int i = 0; i < 16; i++) exp_flat[8*i +: 8] = mdl[m][i];
        vectors++;
        if (reg_out_w[m] !== exp_flat) begin
            miscompares++;
            $display("FAIL wr_rd_regs m%0d: got %h expected %h", m, reg_out_w[m], exp_flat);
        end
    endtask

    task automatic test_burst(input int m);
        int           fd0;
        logic [7:0]   e;
        logic [7:0]   g;
        wr_t          ew;
        obs_t         ow;
        logic [127:0] exp_flat;
        fd0 = fd_cnt[m];
        tx_q = '{8'h0E, 8'h11, 8'h22, 8'h33};
        exp_miso.push_back(8'h5A);
        for (int i = 0; i < 3; i++) exp_miso.push_back(8'h00);
        push_wr(m, 4'hE, 8'h11);
        push_wr(m, 4'hF, 8'h22);
        push_wr(m, 4'h0, 8'h33);
        send_frame(m, 8);
        tx_q = '{8'h8F, 8'hA5, 8'h3C};
        exp_miso.push_back(8'h5A);
        exp_miso.push_back(mdl[m][15]);
        exp_miso.push_back(mdl[m][0]);
        send_frame(m, 8);
        while (exp_miso.size() > 0) begin
            e = exp_miso.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL burst_miso m%0d: got no byte expected %h", m, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL burst_miso m%0d: got %h expected %h", m, g, e);
                end
            end
        end
        got_q.delete();
        while (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            vectors++;
            if (obs_rd >= obs_q.size()) begin
                miscompares++;
                $display("FAIL burst_write m%0d: got none expected a=%h d=%h", m, ew.a, ew.d);
            end else begin
                ow = obs_q[obs_rd];
                obs_rd++;
                if (ow.m != ew.m || ow.a !== ew.a || ow.d !== ew.d || ow.r !== ew.d) begin
                    miscompares++;
                    $display("FAIL burst_write m%0d: got m%0d a=%h d=%h reg=%h expected m%0d a=%h d=%h", m, ow.m, ow.a, ow.d, ow.r, ew.m, ew.a, ew.d);
                end
            end
        end
        vectors++;
        if (obs_q.size() != obs_rd) begin
            miscompares++;
            $display("FAIL burst_extra_writes m%0d: got %0d extra expected 0", m, obs_q.size() - obs_rd);
        end
        obs_rd = obs_q.size();
        vectors++;
        if (fd_cnt[m] - fd0 != 2) begin
            miscompares++;
            $display("FAIL burst_frame_done m%0d: got %0d expected 2", m, fd_cnt[m] - fd0);
        end
        for (int i = 0; i < 16; i++) exp_flat[8*i +: 8] = mdl[m][i];
        vectors++;
        if (reg_out_w[m] !== exp_flat) begin
            miscompares++;
            $display("FAIL burst_regs m%0d: got %h expected %h", m, reg_out_w[m], exp_flat);
        end
    endtask

    task automatic test_partial(input int m);
        int           fd0;
        logic [7:0]   e;
        logic [7:0]   g;
        wr_t          ew;
        obs_t         ow;
        logic [127:0] exp_flat;
        fd0 = fd_cnt[m];
        // Command byte completes, data byte cut after 5 bits: no write, but frame_done.
        tx_q = '{8'h05, 8'hAB};
        exp_miso.push_back(8'h5A);
        send_frame(m, 5);
        vectors++;
        if (reg_out_w[m][8*5 +: 8] !== mdl[m][5]) begin
            miscompares++;
            $display("FAIL partial_reg5 m%0d: got %h expected %h", m, reg_out_w[m][8*5 +: 8], mdl[m][5]);
        end
        vectors++;
        if (fd_cnt[m] - fd0 != 1) begin
            miscompares++;
            $display("FAIL partial_frame_done m%0d: got %0d expected 1", m, fd_cnt[m] - fd0);
        end
        // Frame with no complete byte: no frame_done at all.
        tx_q = '{8'h8A};
        send_frame(m, 3);
        vectors++;
        if (fd_cnt[m] - fd0 != 1) begin
            miscompares++;
            $display("FAIL empty_frame_done m%0d: got %0d expected 1", m, fd_cnt[m] - fd0);
        end
        tx_q = '{8'h05, 8'h3C};
        exp_miso.push_back(8'h5A);
        exp_miso.push_back(8'h00);
        push_wr(m, 4'h5, 8'h3C);
        send_frame(m, 8);
        while (exp_miso.size() > 0) begin
            e = exp_miso.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL partial_miso m%0d: got no byte expected %h", m, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL partial_miso m%0d: got %h expected %h", m, g, e);
                end
            end
        end
        got_q.delete();
        while (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            vectors++;
            if (obs_rd >= obs_q.size()) begin
                miscompares++;
                $display("FAIL partial_write m%0d: got none expected a=%h d=%h", m, ew.a, ew.d);
            end else begin
                ow = obs_q[obs_rd];
                obs_rd++;
                if (ow.m != ew.m || ow.a !== ew.a || ow.d !== ew.d || ow.r !== ew.d) begin
                    miscompares++;
                    $display("FAIL partial_write m%0d: got m%0d a=%h d=%h reg=%h expected m%0d a=%h d=%h", m, ow.m, ow.a, ow.d, ow.r, ew.m, ew.a, ew.d);
                end
            end
        end
        vectors++;
        if (obs_q.size() != obs_rd) begin
            miscompares++;
            $display("FAIL partial_extra_writes m%0d: got %0d extra expected 0", m, obs_q.size() - obs_rd);
        end
        obs_rd = obs_q.size();
        vectors++;
        if (fd_cnt[m] - fd0 != 2) begin
            miscompares++;
            $display("FAIL partial_next_frame_done m%0d: got %0d expected 2", m, fd_cnt[m] - fd0);
        end
        for (int i = 0; i < 16; i++) exp_flat[8*i +: 8] = mdl[m][i];
        vectors++;
        if (reg_out_w[m] !== exp_flat) begin
            miscompares++;
            $display("FAIL partial_regs m%0d: got %h expected %h", m, reg_out_w[m], exp_flat);
        end
    endtask

    task automatic test_reset_mid_frame(input int m);
        int           fd0;
        logic [7:0]   e;
        logic [7:0]   g;
        wr_t          ew;
        obs_t         ow;
        logic [127:0] exp_flat;
        fd0 = fd_cnt[m];
        cs_r[m] = 1'b0;
        half();
        exp_miso.push_back(8'h5A);
        exp_miso.push_back(8'h00);
        push_wr(m, 4'h1, 8'h77);
        xfer(m, 8'h01, 8);
        xfer(m, 8'h77, 8);
        xfer(m, 8'h66, 4);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) mdl[k][i] = 8'h00;
        end
        // cs stayed low through release: these bytes must be ignored with miso held low.
        exp_miso.push_back(8'h00);
        exp_miso.push_back(8'h00);
        xfer(m, 8'h02, 8);
        xfer(m, 8'h88, 8);
        half();
        cs_r[m] = 1'b1;
        half();
        half();
        vectors++;
        if (fd_cnt[m] - fd0 != 0) begin
            miscompares++;
            $display("FAIL rst_mid_frame_done m%0d: got %0d expected 0", m, fd_cnt[m] - fd0);
        end
        tx_q = '{8'h02, 8'h5C};
        exp_miso.push_back(8'h5A);
        exp_miso.push_back(8'h00);
        push_wr(m, 4'h2, 8'h5C);
        send_frame(m, 8);
        while (exp_miso.size() > 0) begin
            e = exp_miso.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("FAIL rst_mid_miso m%0d: got no byte expected %h", m, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL rst_mid_miso m%0d: got %h expected %h", m, g, e);
                end
            end
        end
        got_q.delete();
        while (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            vectors++;
            if (obs_rd >= obs_q.size()) begin
                miscompares++;
                $display("FAIL rst_mid_write m%0d: got none expected a=%h d=%h", m, ew.a, ew.d);
            end else begin
                ow = obs_q[obs_rd];
                obs_rd++;
                if (ow.m != ew.m || ow.a !== ew.a || ow.d !== ew.d || ow.r !== ew.d) begin
                    miscompares++;
                    $display("FAIL rst_mid_write m%0d: got m%0d a=%h d=%h reg=%h expected m%0d a=%h d=%h", m, ow.m, ow.a, ow.d, ow.r, ew.m, ew.a, ew.d);
                end
            end
        end
        vectors++;
        if (obs_q.size() != obs_rd) begin
            miscompares++;
            $display("FAIL rst_mid_extra_writes m%0d: got %0d extra expected 0", m, obs_q.size() - obs_rd);
        end
        obs_rd = obs_q.size();
        vectors++;
        if (fd_cnt[m] - fd0 != 1) begin
            miscompares++;
            $display("FAIL rst_mid_next_frame_done m%0d: got %0d expected 1", m, fd_cnt[m] - fd0);
        end
        for (int i = 0; i < 16; i++) exp_flat[8*i +: 8] = mdl[m][i];
        vectors++;
        if (reg_out_w[m] !== exp_flat) begin
            miscompares++;
            $display("FAIL rst_mid_regs m%0d: got %h expected %h", m, reg_out_w[m], exp_flat);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cs_r[k]   = 1'b1;
            sclk_r[k] = k[1];
            mosi_r[k] = 1'b0;
            for (int i = 0; i < 16; i++) mdl[k][i] = 8'h00;
        end
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        test_reset();
        for (int m = 3; m >= 0; m--) begin
            test_write_read(m);
            test_burst(m);
            test_partial(m);
            test_reset_mid_frame(m);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
